sys_array_feeder: RTL and testbench

Input-side transmitter for the 4x4 convolution systolic array. Accepts a SIZE x SIZE image as a serial word stream and buffers it. On a start command it drives the array's four horizontal lanes with four adjacent image rows, skewed one cycle per lane, plus the matching `srt_sig` pulse. The image is kept after streaming so it can be replayed against a new weight set without reloading.

---
 rtl/sys_feeder_pkg.sv | 15 +
 rtl/skew_delay.sv | 33 +++
 rtl/sys_array_feeder.sv | 166 ++++++++++++++++
 tb/tb_sys_array_feeder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/sys_feeder_pkg.sv
// Shared types and constants for the systolic-array input feeder.
package sys_feeder_pkg;

  typedef enum logic [2:0] {
    ST_EMPTY  = 3'd0,
    ST_FILL   = 3'd1,
    ST_LOADED = 3'd2,
    ST_STREAM = 3'd3,
    ST_DRAIN  = 3'd4
  } feeder_state_t;

  localparam int unsigned LANES    = 4;
  localparam int unsigned SKEW_MAX = 3;

endpackage

// File: rtl/skew_delay.sv
// Zero-reset shift register used to skew the feeder lanes; DEPTH=0 passes through.
module skew_delay #(
  parameter int unsigned DW    = 16,
  parameter int unsigned DEPTH = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic [DW-1:0] d,
  output logic [DW-1:0] q
);

  if (DEPTH == 0) begin : g_pass
    assign q = d;
  end else begin : g_shift
    logic [DW-1:0] sr [DEPTH];

    // Shift the lane sample one stage per cycle; reset and clear flush to zero.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else if (clr) begin
        for (int unsigned i = 0; i < DEPTH; i++) sr[i] <= '0;
      end else begin
        sr[0] <= d;
        for (int unsigned i = 1; i < DEPTH; i++) sr[i] <= sr[i-1];
      end
    end

    assign q = sr[DEPTH-1];
  end

endmodule

// File: rtl/sys_array_feeder.sv
// Buffers a SIZE x SIZE image and streams four adjacent rows, skewed one cycle
// per lane, into the systolic array. Optional macro SYS_FEEDER_ERR_EN builds
// the sticky protocol-error detector behind err.
module sys_array_feeder
  import sys_feeder_pkg::*;
#(
  parameter int SIZE = 6,
  parameter int DW   = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] in,
  input  logic          clear,
  input  logic          start,
  output logic [DW-1:0] out_h1,
  output logic [DW-1:0] out_h2,
  output logic [DW-1:0] out_h3,
  output logic [DW-1:0] out_h4,
  output logic          srt_sig,
  output logic          loaded,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned NPIX = SIZE * SIZE;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned DCW  = $clog2(SKEW_MAX + 1);

  localparam logic [AW-1:0]  PIX_LAST   = AW'(NPIX - 1);
  localparam logic [AW-1:0]  COL_LAST   = AW'(SIZE - 1);
  localparam logic [AW-1:0]  ROW_LAST   = AW'(SIZE - 4);
  localparam logic [DCW-1:0] DRAIN_LAST = DCW'(SKEW_MAX);

  feeder_state_t  state;
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [AW-1:0]  row;
  logic [AW-1:0]  col;
  logic [DCW-1:0] dcnt;
  logic [DW-1:0]  mem   [NPIX];
  logic [DW-1:0]  stage [LANES];
  logic           wr_en;

  assign wr_en  = load && !clear && (state == ST_EMPTY || state == ST_FILL);
  assign loaded = (state == ST_LOADED) || (state == ST_STREAM) || (state == ST_DRAIN);

  // Image buffer write port; contents survive clear and reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in;
  end

  // Control FSM with write pointer and row/column read counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      row    <= '0;
      col    <= '0;
      dcnt   <= '0;
    end else if (clear) begin
      state  <= ST_EMPTY;
      wr_ptr <= '0;
      rd_ptr <= '0;
      row    <= '0;
      col    <= '0;
      dcnt   <= '0;
    end else begin
      case (state)
        ST_EMPTY, ST_FILL: begin
          if (load) begin
            if (wr_ptr == PIX_LAST) begin
              state  <= ST_LOADED;
              wr_ptr <= '0;
            end else begin
              state  <= ST_FILL;
              wr_ptr <= wr_ptr + AW'(1);
            end
          end
        end
        ST_LOADED: begin
          if (start) begin
            state  <= ST_STREAM;
            rd_ptr <= '0;
            row    <= '0;
            col    <= '0;
          end
        end
        ST_STREAM: begin
          rd_ptr <= rd_ptr + AW'(1);
          if (col == COL_LAST) begin
            col <= '0;
            if (row == ROW_LAST) begin
              state <= ST_DRAIN;
              dcnt  <= '0;
            end else begin
              row <= row + AW'(1);
            end
          end else begin
            col <= col + AW'(1);
          end
        end
        ST_DRAIN: begin
          // Exit is taken one edge after the final skewed sample so done lines
          // up with all lanes already returned to zero.
          if (dcnt == DRAIN_LAST) state <= ST_LOADED;
          else                    dcnt  <= dcnt + DCW'(1);
        end
        default: state <= ST_EMPTY;
      endcase
    end
  end

  // Registered buffer reads for every lane plus the stream status pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned k = 0; k < LANES; k++) stage[k] <= '0;
      srt_sig <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else if (clear) begin
      for (int unsigned k = 0; k < LANES; k++) stage[k] <= '0;
      srt_sig <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < LANES; k++)
        stage[k] <= (state == ST_STREAM) ? mem[rd_ptr + AW'(k * SIZE)] : '0;
      srt_sig <= (state == ST_STREAM) && (rd_ptr == '0);
      busy    <= (state == ST_STREAM) || (state == ST_DRAIN && dcnt != DRAIN_LAST);
      done    <= (state == ST_DRAIN) && (dcnt == DRAIN_LAST);
    end
  end

  assign out_h1 = stage[0];

  skew_delay #(.DW(DW), .DEPTH(1)) u_skew2 (
    .clk(clk), .rst_n(rst_n), .clr(clear), .d(stage[1]), .q(out_h2)
  );
  skew_delay #(.DW(DW), .DEPTH(2)) u_skew3 (
    .clk(clk), .rst_n(rst_n), .clr(clear), .d(stage[2]), .q(out_h3)
  );
  skew_delay #(.DW(DW), .DEPTH(3)) u_skew4 (
    .clk(clk), .rst_n(rst_n), .clr(clear), .d(stage[3]), .q(out_h4)
  );

`ifdef SYS_FEEDER_ERR_EN
  logic err_q;

  // Sticky flag for any start or load the current state ignores.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     err_q <= 1'b0;
    else if (clear) err_q <= 1'b0;
    else if ((start && state != ST_LOADED) ||
             (load && state != ST_EMPTY && state != ST_FILL))
      err_q <= 1'b1;
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_sys_array_feeder.sv
// Directed/randomized bench for sys_array_feeder with a row/column reference model.
module tb_sys_array_feeder;

  localparam int SIZE  = 6;
  localparam int DW    = 16;
  localparam int NPIX  = SIZE * SIZE;
  localparam int NBASE = (SIZE - 3) * SIZE;
  localparam int NEND  = NBASE + 4;
`ifdef SYS_FEEDER_ERR_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          load = 1'b0;
  logic [DW-1:0] din = '0;
  logic          clear = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] out_h1, out_h2, out_h3, out_h4;
  logic          srt_sig, loaded, busy, done, err;

  int checks = 0;
  int failures = 0;
  logic [DW-1:0] img [NPIX];
  bit err_exp = 1'b0;

  sys_array_feeder #(.SIZE(SIZE), .DW(DW)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .in(din), .clear(clear), .start(start),
    .out_h1(out_h1), .out_h2(out_h2), .out_h3(out_h3), .out_h4(out_h4),
    .srt_sig(srt_sig), .loaded(loaded), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Lane k (1..4) at edge n after start: base index t = n-k walks the image
  // row-major over the first SIZE-3 rows; lane k reads k-1 rows further down.
  function automatic logic [DW-1:0] lane_exp(input int k, input int n);
    int t;
    t = n - k;
    if (t < 0 || t >= NBASE) return '0;
    return img[(t / SIZE + k - 1) * SIZE + t % SIZE];
  endfunction

  function automatic logic [DW-1:0] lane_out(input int k);
    case (k)
      1: return out_h1;
      2: return out_h2;
      3: return out_h3;
      default: return out_h4;
    endcase
  endfunction

  task automatic check_idle(input string tag);
    for (int k = 1; k <= 4; k++) chk($sformatf("%s_lane%0d", tag, k), lane_out(k), '0);
    chk({tag, "_srt"}, DW'(srt_sig), '0);
    chk({tag, "_busy"}, DW'(busy), '0);
    chk({tag, "_done"}, DW'(done), '0);
    chk({tag, "_err"}, DW'(err), DW'(err_exp));
  endtask

  task automatic load_img(input bit by_index);
    for (int i = 0; i < NPIX; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        load = 1'b0;
        step();
      end
      load = 1'b1;
      din = by_index ? DW'(i) : DW'($urandom);
      img[i] = din;
      step();
      if (i == NPIX - 2) chk("load_not_yet", DW'(loaded), '0);
    end
    load = 1'b0;
    chk("load_full", DW'(loaded), 1);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    step();
    clear = 1'b0;
    err_exp = 1'b0;
    chk("clear_loaded", DW'(loaded), '0);
    check_idle("clear");
  endtask

  // Starts a stream and checks every edge up to last_n; clr_at/poke_at
  // assert clear/start in the cycle sampled at that edge (0 = never).
  task automatic run_stream(input string tag, input int clr_at, input int poke_at, input int last_n);
    bit cleared;
    cleared = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    chk({tag, "_e0_loaded"}, DW'(loaded), 1);
    for (int n = 1; n <= last_n; n++) begin
      if (n == poke_at) start = 1'b1;
      if (n == clr_at) clear = 1'b1;
      step();
      start = 1'b0;
      clear = 1'b0;
      if (n == poke_at) err_exp = ERR_EN;
      if (n == clr_at) begin
        cleared = 1'b1;
        err_exp = 1'b0;
      end
      if (cleared) begin
        check_idle($sformatf("%s_clr_e%0d", tag, n));
        chk($sformatf("%s_clr_loaded_e%0d", tag, n), DW'(loaded), '0);
      end else begin
        for (int k = 1; k <= 4; k++)
          chk($sformatf("%s_e%0d_lane%0d", tag, n, k), lane_out(k), lane_exp(k, n));
        chk($sformatf("%s_e%0d_srt", tag, n), DW'(srt_sig), DW'(n == 1));
        chk($sformatf("%s_e%0d_busy", tag, n), DW'(busy), DW'(n < NEND));
        chk($sformatf("%s_e%0d_done", tag, n), DW'(done), DW'(n == NEND));
        chk($sformatf("%s_e%0d_loaded", tag, n), DW'(loaded), 1);
        chk($sformatf("%s_e%0d_err", tag, n), DW'(err), DW'(err_exp));
      end
    end
  endtask

  initial begin
    for (int i = 0; i < NPIX; i++) img[i] = '0;

    // Reset state
    repeat (2) step();
    chk("rst_loaded", DW'(loaded), '0);
    check_idle("rst");
    rst_n = 1'b1;
    step();

    // Index image, stream, then back-to-back replay with an ignored start
    load_img(1'b1);
    run_stream("s1", 0, 0, NEND);
    run_stream("s2", 0, 4, NEND);
    do_clear();

    // Partial image: start is ignored
    for (int i = 0; i < 20; i++) begin
      load = 1'b1;
      din = DW'($urandom);
      img[i] = din;
      step();
    end
    load = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    err_exp = ERR_EN;
    for (int n = 0; n < 4; n++) begin
      check_idle($sformatf("partial_e%0d", n));
      chk($sformatf("partial_loaded_e%0d", n), DW'(loaded), '0);
      step();
    end
    do_clear();

    // Pixel offered together with clear is dropped
    clear = 1'b1;
    load = 1'b1;
    din = 16'hdead;
    step();
    clear = 1'b0;
    load = 1'b0;
    chk("clrload_loaded", DW'(loaded), '0);
    load_img(1'b0);

    // Loads in LOADED are ignored and must not disturb the buffer
    load = 1'b1;
    din = 16'hbeef;
    step();
    din = 16'h1234;
    step();
    load = 1'b0;
    err_exp = ERR_EN;
    chk("ign_load_err", DW'(err), DW'(err_exp));
    run_stream("s3", 0, 0, NEND);

    // Clear in the middle of a stream
    run_stream("s4", 6, 0, NEND + 3);

    // Clear and start together in LOADED
    load_img(1'b0);
    clear = 1'b1;
    start = 1'b1;
    step();
    clear = 1'b0;
    start = 1'b0;
    err_exp = 1'b0;
    for (int n = 0; n < 4; n++) begin
      check_idle($sformatf("clrstart_e%0d", n));
      chk($sformatf("clrstart_loaded_e%0d", n), DW'(loaded), '0);
      step();
    end

    // Asynchronous reset during DRAIN, then full reload
    load_img(1'b1);
    run_stream("s5", 0, 0, NBASE + 1);
    #2;
    rst_n = 1'b0;
    #1;
    err_exp = 1'b0;
    chk("rstdrain_loaded", DW'(loaded), '0);
    check_idle("rstdrain");
    step();
    rst_n = 1'b1;
    step();
    load_img(1'b1);
    run_stream("s6", 0, 0, NEND);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
